// File: rtl/ps2_pkg.sv
// Shared constants, receive-FSM state encoding and parity helper for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic ps2_odd_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous scan-code FIFO; an extra pointer MSB separates full from empty.
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit frame FSM with watchdog, scan-code FIFO, make/break tracking.
// Define PS2_PARITY_CHECK_EN to discard frames whose odd parity is wrong; otherwise the parity bit is ignored.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] rdata,
    output logic       valid,
    output logic       overflow,
    output logic       frame_err,
    output logic       key_down,
    output logic [7:0] key_code,
    output logic [7:0] press_cnt
);

    localparam int DATA_BITS = PS2_FRAME_BITS - 3;
    localparam int WD_W      = $clog2(TIMEOUT + 1);
`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    logic [2:0]      r_clk_sync;
    logic [1:0]      r_dat_sync;
    ps2_state_e      r_state;
    logic [2:0]      r_bitcnt;
    logic [WD_W-1:0] r_wdog;
    logic [7:0]      r_shift;
    logic            r_par;
    logic            r_brk_pend;
    logic            r_key_down;
    logic [7:0]      r_key_code;
    logic [7:0]      r_press_cnt;
    logic            r_overflow;

    logic       w_fall;
    logic       w_bit;
    logic       w_timeout;
    logic       w_stop_ev;
    logic       w_par_ok;
    logic       w_good;
    logic       w_push;
    logic       w_ferr;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;

    // Flops reset to 1 (idle bus level) so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit     = r_dat_sync[1];
    assign w_timeout = (r_state != ST_IDLE) && (r_wdog == WD_W'(TIMEOUT));
    assign w_stop_ev = w_fall & (r_state == ST_STOP) & ~w_timeout & ~rst;
    assign w_par_ok  = ~PARITY_EN | ps2_odd_ok(r_shift, r_par);
    assign w_good    = w_bit & w_par_ok;
    assign w_push    = w_stop_ev & w_good;
    assign w_ferr    = ~rst & (w_timeout | (w_stop_ev & ~w_good));
    assign frame_err = w_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_wdog   <= '0;
        end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_wdog  <= '0;
        end else if (w_fall) begin
            r_wdog <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_bit) begin
                        r_state  <= ST_DATA;
                        r_bitcnt <= '0;
                    end
                end
                ST_DATA: begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'(DATA_BITS - 1))
                        r_state <= ST_PARITY;
                end
                ST_PARITY: r_state <= ST_STOP;
                default:   r_state <= ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE) begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end

    // Data bits arrive LSB first, so shift right and insert at the MSB.
    always_ff @(posedge clk) begin
        if (w_fall && r_state == ST_DATA)
            r_shift <= {w_bit, r_shift[7:1]};
        if (w_fall && r_state == ST_PARITY)
            r_par <= w_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_brk_pend  <= 1'b0;
            r_key_down  <= 1'b0;
            r_key_code  <= '0;
            r_press_cnt <= '0;
        end else if (w_push) begin
            if (r_shift == PS2_BREAK) begin
                r_brk_pend <= 1'b1;
            end else if (r_shift == PS2_EXT) begin
                r_brk_pend <= r_brk_pend;
            end else if (r_brk_pend) begin
                r_key_down <= 1'b0;
                r_key_code <= r_shift;
                r_brk_pend <= 1'b0;
            end else begin
                // Typematic repeats of the held key do not count as new presses.
                if (!r_key_down || r_shift != r_key_code)
                    r_press_cnt <= r_press_cnt + 8'd1;
                r_key_down <= 1'b1;
                r_key_code <= r_shift;
            end
        end
    end

    assign w_pop = rd_en & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst)
            r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop)
            r_overflow <= 1'b1;
    end

    ps2_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (r_shift),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rdata     = w_head;
    assign valid     = ~w_empty;
    assign overflow  = r_overflow;
    assign key_down  = r_key_down;
    assign key_code  = r_key_code;
    assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames are bit-banged on the PS/2 pins and outputs compared to hand-computed values.
module tb_ps2_kbd_rx;

    localparam int TO    = 200;
    localparam int DEPTH = 8;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rdata;
    logic       valid;
    logic       overflow;
    logic       frame_err;
    logic       key_down;
    logic [7:0] key_code;
    logic [7:0] press_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;

    ps2_kbd_rx #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .rdata     (rdata),
        .valid     (valid),
        .overflow  (overflow),
        .frame_err (frame_err),
        .key_down  (key_down),
        .key_code  (key_code),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1)
            ferr_cnt++;
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++)
            ps2_bit(d[i]);
        ps2_bit(~(^d) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_en    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (valid !== 1'b0)     begin n_fail++; $display("FAIL rst_valid got %b want 0", valid); end
        n_checks++; if (rdata !== 8'h00)    begin n_fail++; $display("FAIL rst_rdata got %h want 00", rdata); end
        n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL rst_overflow got %b want 0", overflow); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err got %b want 0", frame_err); end
        n_checks++; if (key_down !== 1'b0)  begin n_fail++; $display("FAIL rst_key_down got %b want 0", key_down); end
        n_checks++; if (key_code !== 8'h00) begin n_fail++; $display("FAIL rst_key_code got %h want 00", key_code); end
        n_checks++; if (press_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_press_cnt got %h want 00", press_cnt); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (valid !== 1'b0 || ferr_cnt !== 0) begin n_fail++; $display("FAIL rst_idle valid=%b ferr=%0d want 0/0", valid, ferr_cnt); end
    endtask

    task automatic test_make_break();
        logic [7:0] exp [3];
        exp[0] = 8'h1C; exp[1] = 8'hF0; exp[2] = 8'h1C;
        do_reset();
        send_frame(8'h1C, 1'b0);
        n_checks++; if (key_down !== 1'b1)   begin n_fail++; $display("FAIL mk_key_down got %b want 1", key_down); end
        n_checks++; if (key_code !== 8'h1C)  begin n_fail++; $display("FAIL mk_key_code got %h want 1c", key_code); end
        n_checks++; if (press_cnt !== 8'h01) begin n_fail++; $display("FAIL mk_press_cnt got %h want 01", press_cnt); end
        send_frame(8'hF0, 1'b0);
        n_checks++; if (key_down !== 1'b1 || key_code !== 8'h1C) begin n_fail++; $display("FAIL brk_prefix key_down=%b code=%h want 1/1c", key_down, key_code); end
        send_frame(8'h1C, 1'b0);
        n_checks++; if (key_down !== 1'b0)   begin n_fail++; $display("FAIL brk_key_down got %b want 0", key_down); end
        n_checks++; if (press_cnt !== 8'h01) begin n_fail++; $display("FAIL brk_press_cnt got %h want 01", press_cnt); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (valid !== 1'b1 || rdata !== exp[i]) begin
                n_fail++; $display("FAIL mb_pop%0d valid=%b rdata=%h want 1/%h", i, valid, rdata, exp[i]);
            end
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mb_empty valid got %b want 0", valid); end
    endtask

    task automatic test_typematic();
        do_reset();
        repeat (3) send_frame(8'h1C, 1'b0);
        n_checks++; if (press_cnt !== 8'h01 || key_down !== 1'b1) begin n_fail++; $display("FAIL typ_repeat press=%h down=%b want 01/1", press_cnt, key_down); end
        send_frame(8'h32, 1'b0);
        n_checks++; if (press_cnt !== 8'h02) begin n_fail++; $display("FAIL typ_press_cnt got %h want 02", press_cnt); end
        n_checks++; if (key_code !== 8'h32)  begin n_fail++; $display("FAIL typ_key_code got %h want 32", key_code); end
    endtask

    task automatic test_bad_parity();
        int f0;
        do_reset();
        f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL par_ferr got %0d pulses want 1", ferr_cnt - f0); end
        n_checks++; if (valid !== 1'b0)      begin n_fail++; $display("FAIL par_valid got %b want 0", valid); end
        n_checks++; if (press_cnt !== 8'h00) begin n_fail++; $display("FAIL par_press_cnt got %h want 00", press_cnt); end
`else
        n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL par_ferr got %0d pulses want 0", ferr_cnt - f0); end
        n_checks++; if (valid !== 1'b1 || rdata !== 8'h1C) begin n_fail++; $display("FAIL par_accept valid=%b rdata=%h want 1/1c", valid, rdata); end
        n_checks++; if (press_cnt !== 8'h01) begin n_fail++; $display("FAIL par_press_cnt got %h want 01", press_cnt); end
`endif
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 8; i++)
            send_frame(8'(8'h10 + i), 1'b0);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at8 got %b want 0", overflow); end
        send_frame(8'h18, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_at9 got %b want 1", overflow); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (valid !== 1'b1 || rdata !== 8'(8'h10 + i)) begin
                n_fail++; $display("FAIL ovf_pop%0d valid=%b rdata=%h want 1/%h", i, valid, rdata, 8'(8'h10 + i));
            end
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        n_checks++; if (valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drained valid=%b ovf=%b want 0/1", valid, overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++)
            send_frame(8'(8'h20 + i), 1'b0);
        d_send_with_pop(8'h28);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow got %b want 0", overflow); end
        for (int i = 1; i < 9; i++) begin
            n_checks++;
            if (valid !== 1'b1 || rdata !== 8'(8'h20 + i)) begin
                n_fail++; $display("FAIL fpp_pop%0d valid=%b rdata=%h want 1/%h", i, valid, rdata, 8'(8'h20 + i));
            end
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty valid got %b want 0", valid); end
    endtask

    // Sends a frame and raises rd_en for exactly the cycle in which the stop-bit fall is decoded.
    task automatic d_send_with_pop(input logic [7:0] d);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++)
            ps2_bit(d[i]);
        ps2_bit(~(^d));
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_timeout();
        int f0;
        do_reset();
        f0 = ferr_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++)
            ps2_bit(i[0]);
        repeat (TO + 30) @(negedge clk);
        n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL to_ferr got %0d pulses want 1", ferr_cnt - f0); end
        n_checks++; if (valid !== 1'b0)      begin n_fail++; $display("FAIL to_valid got %b want 0", valid); end
        send_frame(8'h45, 1'b0);
        n_checks++; if (valid !== 1'b1 || rdata !== 8'h45) begin n_fail++; $display("FAIL to_next valid=%b rdata=%h want 1/45", valid, rdata); end
        n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL to_no_extra got %0d pulses want 1", ferr_cnt - f0); end
    endtask

    task automatic test_mid_reset();
        int         f0;
        logic [7:0] d;
        d = 8'h1C;
        do_reset();
        send_frame(8'h33, 1'b0);
        f0 = ferr_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++)
            ps2_bit(d[i]);
        @(negedge clk);
        ps2_data = d[3];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (valid !== 1'b0 || rdata !== 8'h00) begin n_fail++; $display("FAIL mr_fifo valid=%b rdata=%h want 0/00", valid, rdata); end
        n_checks++; if (key_down !== 1'b0 || key_code !== 8'h00 || press_cnt !== 8'h00) begin
            n_fail++; $display("FAIL mr_keys down=%b code=%h cnt=%h want 0/00/00", key_down, key_code, press_cnt);
        end
        n_checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL mr_flags ovf=%b ferr=%b want 0/0", overflow, frame_err); end
        rst = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (TO + 30) @(negedge clk);
        n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL mr_no_ferr got %0d pulses want 0", ferr_cnt - f0); end
        send_frame(8'h45, 1'b0);
        n_checks++; if (valid !== 1'b1 || rdata !== 8'h45) begin n_fail++; $display("FAIL mr_next valid=%b rdata=%h want 1/45", valid, rdata); end
        n_checks++; if (key_code !== 8'h45 || press_cnt !== 8'h01) begin n_fail++; $display("FAIL mr_next_key code=%h cnt=%h want 45/01", key_code, press_cnt); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_typematic();
        test_bad_parity();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
